pll_lock_sequencer: RTL and testbench



---
 rtl/pll_lock_sequencer_pkg.sv | 25 ++
 rtl/pll_lock_sequencer_if.sv | 25 ++
 rtl/pll_lock_sequencer_sync.sv | 25 ++
 rtl/pll_lock_sequencer.sv | 171 +++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
// Pure declarations: no latency, no flow control.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_e;

  localparam int RETRY_W   = 2;
  localparam int RETRY_SAT = 3;

  // Counter width: one spare bit above the widest cycle parameter so terminal compares never wrap.
  function automatic int ctr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Board-side bundle of the sequencer: PLL lock/reset, system reset request and status.
// Level signals only; restart is a single-cycle request with no handshake.
interface pll_lock_sequencer_if;
  import pll_seq_pkg::*;

  logic               pll_locked;
  logic               restart;
  logic               pll_resetb;
  logic               sys_rst_n;
  logic               ready;
  logic               fail;
  logic               lock_lost;
  logic [RETRY_W-1:0] retry_count;

  modport master (
    input  pll_locked, restart,
    output pll_resetb, sys_rst_n, ready, fail, lock_lost, retry_count
  );

  modport slave (
    output pll_locked, restart,
    input  pll_resetb, sys_rst_n, ready, fail, lock_lost, retry_count
  );

endinterface

// File: rtl/pll_lock_sequencer_sync.sv
// Two-flop synchroniser for a single asynchronous level; 2 clk edges latency.
// No flow control; both flops clear on rst_n.
module sync_1bit (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer on the reference clock: reset pulse, lock wait, stability filter, run monitor, bounded retry.
// All outputs registered; lock seen 2 edges after the pin, acted on the next edge; restart overrides everything.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES   = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pll_lock_sequencer_if.master bus
);

  localparam int W_CTR = ctr_width(RESET_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);

  localparam logic [W_CTR-1:0]   RESET_LAST   = W_CTR'(RESET_CYCLES - 1);
  localparam logic [W_CTR-1:0]   STABLE_LAST  = W_CTR'(STABLE_CYCLES - 1);
  localparam logic [W_CTR-1:0]   TIMEOUT_LAST = W_CTR'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_TOP    = RETRY_W'(RETRY_SAT);

  if (MAX_RETRIES > RETRY_SAT || MAX_RETRIES < 0) begin : g_bad_max_retries
    $error("pll_lock_sequencer: MAX_RETRIES must be in 0..3");
  end
  if (RESET_CYCLES < 1 || STABLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
    $error("pll_lock_sequencer: cycle parameters must be at least 1");
  end

  logic w_locked_s;

  sync_1bit u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.pll_locked),
    .o_q   (w_locked_s)
  );

  state_e             r_state,      w_state_nxt;
  logic [W_CTR-1:0]   r_ctr,        w_ctr_nxt;
  logic [RETRY_W-1:0] r_retry,      w_retry_nxt;
  logic               r_pll_resetb, w_pll_resetb_nxt;
  logic               r_sys_rst_n,  w_sys_rst_n_nxt;
  logic               r_ready,      w_ready_nxt;
  logic               r_fail,       w_fail_nxt;
  logic               r_lock_lost,  w_lock_lost_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= PLL_RESET;
      r_ctr        <= '0;
      r_retry      <= '0;
      r_pll_resetb <= 1'b0;
      r_sys_rst_n  <= 1'b0;
      r_ready      <= 1'b0;
      r_fail       <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ctr        <= w_ctr_nxt;
      r_retry      <= w_retry_nxt;
      r_pll_resetb <= w_pll_resetb_nxt;
      r_sys_rst_n  <= w_sys_rst_n_nxt;
      r_ready      <= w_ready_nxt;
      r_fail       <= w_fail_nxt;
      r_lock_lost  <= w_lock_lost_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ctr_nxt        = r_ctr;
    w_retry_nxt      = r_retry;
    w_pll_resetb_nxt = r_pll_resetb;
    w_sys_rst_n_nxt  = r_sys_rst_n;
    w_ready_nxt      = r_ready;
    w_fail_nxt       = r_fail;
    w_lock_lost_nxt  = r_lock_lost;

    if (bus.restart) begin
      w_state_nxt      = PLL_RESET;
      w_ctr_nxt        = '0;
      w_retry_nxt      = '0;
      w_pll_resetb_nxt = 1'b0;
      w_sys_rst_n_nxt  = 1'b0;
      w_ready_nxt      = 1'b0;
      w_fail_nxt       = 1'b0;
      w_lock_lost_nxt  = 1'b0;
    end else begin
      case (r_state)
        PLL_RESET: begin
          w_pll_resetb_nxt = 1'b0;
          w_sys_rst_n_nxt  = 1'b0;
          w_ready_nxt      = 1'b0;
          if (r_ctr == RESET_LAST) begin
            w_state_nxt      = WAIT_LOCK;
            w_ctr_nxt        = '0;
            w_pll_resetb_nxt = 1'b1;
          end else begin
            w_ctr_nxt = r_ctr + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (w_locked_s) begin
            w_state_nxt = STABLE;
            w_ctr_nxt   = '0;
          end else if (r_ctr == TIMEOUT_LAST) begin
            w_ctr_nxt        = '0;
            w_pll_resetb_nxt = 1'b0;
            if (r_retry == RETRY_MAX) begin
              w_state_nxt = FAIL;
              w_fail_nxt  = 1'b1;
            end else begin
              w_state_nxt = PLL_RESET;
              if (r_retry != RETRY_TOP) w_retry_nxt = r_retry + 1'b1;
            end
          end else begin
            w_ctr_nxt = r_ctr + 1'b1;
          end
        end
        STABLE: begin
          // A drop here is a glitch, not a failed attempt: reopen the lock window without charging a retry.
          if (!w_locked_s) begin
            w_state_nxt = WAIT_LOCK;
            w_ctr_nxt   = '0;
          end else if (r_ctr == STABLE_LAST) begin
            w_state_nxt     = RUN;
            w_ctr_nxt       = '0;
            w_retry_nxt     = '0;
            w_sys_rst_n_nxt = 1'b1;
            w_ready_nxt     = 1'b1;
          end else begin
            w_ctr_nxt = r_ctr + 1'b1;
          end
        end
        RUN: begin
          if (!w_locked_s) begin
            w_state_nxt      = PLL_RESET;
            w_ctr_nxt        = '0;
            w_pll_resetb_nxt = 1'b0;
            w_sys_rst_n_nxt  = 1'b0;
            w_ready_nxt      = 1'b0;
            w_lock_lost_nxt  = 1'b1;
          end
        end
        FAIL: begin
          w_pll_resetb_nxt = 1'b0;
          w_sys_rst_n_nxt  = 1'b0;
          w_ready_nxt      = 1'b0;
          w_fail_nxt       = 1'b1;
        end
        default: begin
          w_state_nxt      = PLL_RESET;
          w_ctr_nxt        = '0;
          w_pll_resetb_nxt = 1'b0;
          w_sys_rst_n_nxt  = 1'b0;
          w_ready_nxt      = 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_resetb  = r_pll_resetb;
  assign bus.sys_rst_n   = r_sys_rst_n;
  assign bus.ready       = r_ready;
  assign bus.fail        = r_fail;
  assign bus.lock_lost   = r_lock_lost;
  assign bus.retry_count = r_retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small cycle parameters; expected edge counts derived by hand.
module tb_pll_lock_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  pll_lock_sequencer_if u_if ();

  pll_lock_sequencer #(
    .RESET_CYCLES   (4),
    .STABLE_CYCLES  (8),
    .TIMEOUT_CYCLES (32),
    .MAX_RETRIES    (2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, want);
    end
  endtask

  // Advance n rising edges and settle on the following falling edge.
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_restart();
    u_if.restart = 1'b1;
    @(negedge clk);
    u_if.restart = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_resetb"}, u_if.pll_resetb, 0);
    chk({tag, "_sysrst"}, u_if.sys_rst_n, 0);
    chk({tag, "_ready"},  u_if.ready, 0);
    chk({tag, "_fail"},   u_if.fail, 0);
    chk({tag, "_lost"},   u_if.lock_lost, 0);
    chk({tag, "_retry"},  u_if.retry_count, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    u_if.pll_locked = 1'b0;
    u_if.restart    = 1'b0;
    adv(2);
    chk_idle("rst");

    // Nominal bring-up: lock arrives ~10 cycles into the wait window.
    rst_n = 1'b1;
    adv(3);
    chk("nom_resetb_e3", u_if.pll_resetb, 0);
    adv(1);
    chk("nom_resetb_e4", u_if.pll_resetb, 1);
    adv(9);
    u_if.pll_locked = 1'b1;
    adv(10);
    chk("nom_ready_e10", u_if.ready, 0);
    chk("nom_sys_e10", u_if.sys_rst_n, 0);
    adv(1);
    chk("nom_ready_e11", u_if.ready, 1);
    chk("nom_sys_e11", u_if.sys_rst_n, 1);
    chk("nom_retry", u_if.retry_count, 0);
    chk("nom_resetb", u_if.pll_resetb, 1);

    // Lock loss in RUN, then automatic rerun with lock back.
    u_if.pll_locked = 1'b0;
    adv(2);
    chk("loss_ready_e2", u_if.ready, 1);
    u_if.pll_locked = 1'b1;
    adv(1);
    chk("loss_ready_e3", u_if.ready, 0);
    chk("loss_sys_e3", u_if.sys_rst_n, 0);
    chk("loss_resetb_e3", u_if.pll_resetb, 0);
    chk("loss_lost_e3", u_if.lock_lost, 1);
    adv(3);
    chk("loss_resetb_lo", u_if.pll_resetb, 0);
    adv(1);
    chk("loss_resetb_hi", u_if.pll_resetb, 1);
    adv(8);
    chk("loss_ready_pre", u_if.ready, 0);
    adv(1);
    chk("loss_ready_run", u_if.ready, 1);
    chk("loss_lost_run", u_if.lock_lost, 1);

    // Restart while in RUN clears sticky lock_lost.
    pulse_restart();
    chk("rsr_lost", u_if.lock_lost, 0);
    chk("rsr_ready", u_if.ready, 0);
    chk("rsr_sys", u_if.sys_rst_n, 0);
    chk("rsr_resetb", u_if.pll_resetb, 0);
    adv(3);
    chk("rsr_resetb_e3", u_if.pll_resetb, 0);
    adv(1);
    chk("rsr_resetb_e4", u_if.pll_resetb, 1);
    adv(8);
    chk("rsr_ready_pre", u_if.ready, 0);
    adv(1);
    chk("rsr_ready_run", u_if.ready, 1);

    // Glitch in STABLE: 5 high, 1 low, high again.
    u_if.pll_locked = 1'b0;
    pulse_restart();
    chk("gl_lost", u_if.lock_lost, 0);
    adv(4);
    chk("gl_resetb", u_if.pll_resetb, 1);
    u_if.pll_locked = 1'b1;
    adv(5);
    u_if.pll_locked = 1'b0;
    adv(1);
    u_if.pll_locked = 1'b1;
    adv(10);
    chk("gl_ready_e20", u_if.ready, 0);
    chk("gl_retry", u_if.retry_count, 0);
    adv(1);
    chk("gl_ready_e21", u_if.ready, 1);

    // No lock at all: three attempts, then sticky FAIL.
    u_if.pll_locked = 1'b0;
    pulse_restart();
    for (int i = 0; i < 3; i++) begin
      adv(3);
      chk($sformatf("to%0d_resetb_lo", i), u_if.pll_resetb, 0);
      chk($sformatf("to%0d_retry", i), u_if.retry_count, i);
      adv(1);
      chk($sformatf("to%0d_resetb_hi", i), u_if.pll_resetb, 1);
      adv(31);
      chk($sformatf("to%0d_resetb_end", i), u_if.pll_resetb, 1);
      chk($sformatf("to%0d_fail_pre", i), u_if.fail, 0);
      adv(1);
      chk($sformatf("to%0d_resetb_after", i), u_if.pll_resetb, 0);
      if (i < 2) chk($sformatf("to%0d_retry_next", i), u_if.retry_count, i + 1);
    end
    chk("fail_flag", u_if.fail, 1);
    chk("fail_retry", u_if.retry_count, 2);
    chk("fail_sys", u_if.sys_rst_n, 0);
    adv(50);
    chk("fail_hold", u_if.fail, 1);
    chk("fail_hold_resetb", u_if.pll_resetb, 0);
    chk("fail_hold_sys", u_if.sys_rst_n, 0);

    // Restart out of FAIL.
    pulse_restart();
    chk("rsf_fail", u_if.fail, 0);
    chk("rsf_retry", u_if.retry_count, 0);
    adv(3);
    chk("rsf_resetb_e3", u_if.pll_resetb, 0);
    adv(1);
    chk("rsf_resetb_e4", u_if.pll_resetb, 1);

    // Async reset while in STABLE, then a full clean sequence.
    u_if.pll_locked = 1'b1;
    adv(5);
    chk("ar_ready_pre", u_if.ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("ar");
    @(negedge clk);
    rst_n = 1'b1;
    adv(3);
    chk("ar_resetb_e3", u_if.pll_resetb, 0);
    adv(1);
    chk("ar_resetb_e4", u_if.pll_resetb, 1);
    adv(8);
    chk("ar_ready_e12", u_if.ready, 0);
    adv(1);
    chk("ar_ready_e13", u_if.ready, 1);
    chk("ar_retry", u_if.retry_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
